crc16_frame_serializer: RTL and testbench

CRC16_FRAME_SERIALIZER -- requirements
Module: crc16_frame_serializer

---
 rtl/crc_frame_pkg.sv | 26 ++
 rtl/crc16_frame_serializer.sv | 150 +++++++++++++++
 tb/tb_crc16_frame_serializer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_frame_pkg.sv
// -----------------------------------------------------------------------------
// crc_frame_pkg
// Shared definitions for the CRC16 frame serializer:
//   state_t                - serializer FSM states
//   DEFAULT_PAYLOAD_BYTES  - default payload length in bytes
//   FRAME_BYTES            - default frame length (payload + 2 CRC bytes)
//   CRC_WIDTH              - width of the appended CRC
//   frame_bytes()          - frame length for an arbitrary payload length
// -----------------------------------------------------------------------------
package crc_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_CRC = 2'd1,
    ST_SEND     = 2'd2
  } state_t;

  localparam int DEFAULT_PAYLOAD_BYTES = 12;
  localparam int CRC_WIDTH             = 16;
  localparam int FRAME_BYTES           = DEFAULT_PAYLOAD_BYTES + CRC_WIDTH / 8;

  function automatic int frame_bytes(input int payload_bytes);
    return payload_bytes + CRC_WIDTH / 8;
  endfunction

endpackage

// File: rtl/crc16_frame_serializer.sv
// -----------------------------------------------------------------------------
// crc16_frame_serializer
// Captures a payload on start, waits for a fresh CRC from an upstream CRC16
// generator (rising edge of crc_valid), then streams payload bytes MSB first
// followed by CRC[15:8] and CRC[7:0] over a valid/ready byte interface.
// If no CRC edge arrives within CRC_TIMEOUT cycles the frame is dropped and
// crc_timeout pulses for one cycle.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   data_in_ori  in   payload, 8*PAYLOAD_BYTES bits, MSB byte sent first
//   start        in   payload load strobe, honoured only in IDLE
//   crc_16       in   CRC value from upstream
//   crc_valid    in   CRC valid level; its rising edge latches crc_16
//   tx_data      out  serialized byte
//   tx_valid     out  tx_data is valid
//   tx_ready     in   downstream accepts byte when tx_valid && tx_ready
//   tx_last      out  marks the final (CRC low) byte
//   busy         out  high whenever not IDLE
//   crc_timeout  out  one-cycle pulse when the CRC wait is abandoned
// -----------------------------------------------------------------------------
module crc16_frame_serializer
  import crc_frame_pkg::*;
#(
  parameter int PAYLOAD_BYTES = DEFAULT_PAYLOAD_BYTES,
  parameter int CRC_TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [8*PAYLOAD_BYTES-1:0] data_in_ori,
  input  logic                       start,
  input  logic [CRC_WIDTH-1:0]       crc_16,
  input  logic                       crc_valid,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       tx_last,
  output logic                       busy,
  output logic                       crc_timeout
);

  localparam int FRAME_LEN = frame_bytes(PAYLOAD_BYTES);
  localparam int PAYLOAD_W = 8 * PAYLOAD_BYTES;
  localparam int FRAME_W   = 8 * FRAME_LEN;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int CNT_W     = (CRC_TIMEOUT > 1) ? $clog2(CRC_TIMEOUT) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(CRC_TIMEOUT - 1);

  state_t               state_reg;
  state_t               state_next;
  logic [PAYLOAD_W-1:0] payload_reg;
  logic [FRAME_W-1:0]   frame_reg;
  logic [IDX_W-1:0]     byte_idx_reg;
  logic [CNT_W-1:0]     timeout_cnt_reg;
  logic                 crc_valid_d_reg;
  logic                 crc_timeout_reg;

  logic crc_edge;
  logic byte_accept;
  logic last_byte;
  logic wait_expired;

  // Only a 0->1 transition counts, so a level left high from an earlier
  // frame can never release a new one.
  assign crc_edge     = crc_valid & ~crc_valid_d_reg;
  assign byte_accept  = tx_valid & tx_ready;
  assign last_byte    = (byte_idx_reg == LAST_IDX);
  // A CRC edge on the final wait cycle takes priority over the abort.
  assign wait_expired = (state_reg == ST_WAIT_CRC) && !crc_edge &&
                        (timeout_cnt_reg == TIMEOUT_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_WAIT_CRC;
      end
      ST_WAIT_CRC: begin
        if (crc_edge)          state_next = ST_SEND;
        else if (wait_expired) state_next = ST_IDLE;
      end
      ST_SEND: begin
        if (byte_accept && last_byte) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic; the byte on the wire is always the top byte of the
  // shifting frame register, so no wide byte-select mux is needed.
  always_comb begin
    tx_valid    = (state_reg == ST_SEND);
    busy        = (state_reg != ST_IDLE);
    tx_last     = (state_reg == ST_SEND) && last_byte;
    tx_data     = (state_reg == ST_SEND) ? frame_reg[FRAME_W-1 -: 8] : 8'h00;
    crc_timeout = crc_timeout_reg;
  end

  // Datapath: payload buffer, frame shifter, byte index, wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      payload_reg     <= '0;
      frame_reg       <= '0;
      byte_idx_reg    <= '0;
      timeout_cnt_reg <= '0;
      crc_valid_d_reg <= 1'b0;
      crc_timeout_reg <= 1'b0;
    end else begin
      crc_valid_d_reg <= crc_valid;
      crc_timeout_reg <= wait_expired;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            payload_reg     <= data_in_ori;
            timeout_cnt_reg <= '0;
          end
        end
        ST_WAIT_CRC: begin
          if (crc_edge) begin
            frame_reg    <= {payload_reg, crc_16};
            byte_idx_reg <= '0;
          end else if (!wait_expired) begin
            timeout_cnt_reg <= timeout_cnt_reg + CNT_W'(1);
          end
        end
        ST_SEND: begin
          if (byte_accept) begin
            frame_reg    <= frame_reg << 8;
            byte_idx_reg <= last_byte ? '0 : byte_idx_reg + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc16_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_crc16_frame_serializer
// Self-checking bench: a queue-based model of the frame (bytes still owed to
// the receiver, whether a CRC is awaited, how long it has been awaited) is
// compared against the DUT every cycle; directed frames pin the model with
// literal byte sequences and timing, then randomized frames exercise stalls,
// stray starts, pre-asserted crc_valid, timeouts and mid-frame resets.
// -----------------------------------------------------------------------------
module tb_crc16_frame_serializer;

  localparam int PB = 12;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [8*PB-1:0] data_in_ori = '0;
  logic          start = 1'b0;
  logic [15:0]   crc_16 = '0;
  logic          crc_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          tx_last;
  logic          busy;
  logic          crc_timeout;

  crc16_frame_serializer #(.PAYLOAD_BYTES(PB), .CRC_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .data_in_ori(data_in_ori), .start(start),
    .crc_16(crc_16), .crc_valid(crc_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .crc_timeout(crc_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          started = 1'b0;
  bit [7:0]    m_q[$];        // bytes still owed to the receiver
  bit          m_wait = 1'b0; // payload captured, CRC awaited
  int          m_wait_n = 0;  // cycles already spent waiting
  bit          m_to = 1'b0;
  bit          m_prev = 1'b0;
  bit [8*PB-1:0] m_payload = '0;
  bit          edge_seen;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_q.delete();
      m_wait = 1'b0; m_wait_n = 0; m_to = 1'b0; m_prev = 1'b0;
    end else begin
      edge_seen = crc_valid && !m_prev;
      m_to = 1'b0;
      if (m_q.size() > 0) begin
        if (tx_ready) void'(m_q.pop_front());
      end else if (m_wait) begin
        if (edge_seen) begin
          m_wait = 1'b0;
          for (int i = PB - 1; i >= 0; i--) m_q.push_back(m_payload[8*i +: 8]);
          m_q.push_back(crc_16[15:8]);
          m_q.push_back(crc_16[7:0]);
        end else begin
          m_wait_n++;
          if (m_wait_n == TO) begin m_wait = 1'b0; m_to = 1'b1; end
        end
      end else if (start) begin
        m_payload = data_in_ori; m_wait = 1'b1; m_wait_n = 0;
      end
      m_prev = crc_valid;
    end
  end

  // ---------------- per-cycle compare + logging ----------------
  int       valid_cnt = 0;
  int       to_cnt = 0;
  bit [7:0] acc_log[$];
  bit       last_log[$];

  always @(negedge clk) begin
    if (started) begin
      check("tx_valid", 32'(tx_valid), 32'(m_q.size() > 0));
      check("busy", 32'(busy), 32'(m_wait || m_q.size() > 0));
      check("crc_timeout", 32'(crc_timeout), 32'(m_to));
      if (m_q.size() > 0) begin
        check("tx_data", 32'(tx_data), 32'(m_q[0]));
        check("tx_last", 32'(tx_last), 32'(m_q.size() == 1));
      end
      if (tx_valid === 1'b1) valid_cnt++;
      if (crc_timeout === 1'b1) to_cnt++;
      if (tx_valid === 1'b1 && tx_ready) begin
        acc_log.push_back(tx_data);
        last_log.push_back(tx_last);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 2) == 0;
      2:       return 1'($urandom % 2);
      default: return ($urandom % 4) != 0;
    endcase
  endfunction

  int frame_no = 0;

  // One frame: load payload, wait `delay` cycles, raise crc_valid (with a
  // forced low cycle first when it was already high), then drain.
  task automatic frame(input bit [8*PB-1:0] p, input bit [15:0] c, input int delay,
                       input int rmode, input bit pre_high, input int rst_at, input bit glitch);
    bit exp_send;
    int to0;
    bit [7:0] eb;
    acc_log.delete(); last_log.delete();
    valid_cnt = 0; to0 = to_cnt;
    crc_valid = pre_high; data_in_ori = p; start = 1'b1;
    tick();
    start = 1'b0; data_in_ori = {$urandom, $urandom, $urandom};
    repeat (delay) tick();
    if (pre_high) begin crc_valid = 1'b0; tick(); end
    crc_valid = 1'b1; crc_16 = c;
    tick();
    crc_16 = 16'($urandom);
    // Edge arrives on wait cycle `delay` (+1 with the forced low cycle);
    // wait cycles 0..TO-1 still accept it.
    exp_send = ((pre_high ? delay + 1 : delay) <= TO - 1);
    check("first_byte_latency", 32'(tx_valid), 32'(exp_send));
    for (int k = 0; k < 400 && busy === 1'b1; k++) begin
      tx_ready = ready_for(rmode, k);
      if (glitch) begin
        start = ($urandom % 3) == 0;
        data_in_ori = '1;
      end
      if (k == rst_at) begin
        rst = 1'b1; tx_ready = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_tx_valid", 32'(tx_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
      end else begin
        tick();
      end
    end
    start = 1'b0; crc_valid = 1'b0;
    check("frame_done", 32'(busy), 32'(0));
    check("timeout_pulses", 32'(to_cnt - to0), 32'(exp_send ? 0 : 1));
    if (exp_send && rst_at < 0) begin
      check("frame_len", 32'(acc_log.size()), 32'(PB + 2));
      for (int i = 0; i < acc_log.size() && i < PB + 2; i++) begin
        eb = (i < PB) ? p[8*(PB-1-i) +: 8] : (i == PB) ? c[15:8] : c[7:0];
        check("frame_byte", 32'(acc_log[i]), 32'(eb));
      end
    end else if (!exp_send) begin
      check("no_bytes", 32'(valid_cnt), 32'(0));
    end
    $display("frame %0d: delay=%0d ready_mode=%0d pre_high=%0b rst_at=%0d glitch=%0b accepted=%0d timeouts=%0d",
             frame_no, delay, rmode, pre_high, rst_at, glitch, acc_log.size(), to_cnt - to0);
    frame_no++;
    tick();
  endtask

  localparam logic [8*PB-1:0] P34 = 96'hAA5500112233445566778899;
  bit [7:0] exp34 [PB+2] = '{8'hAA, 8'h55, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                            8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'h1D, 8'h0F};

  initial begin
    int first_to;
    int to0;

    // Reset values
    rst = 1'b1;
    tick(); tick();
    check("reset_tx_data", 32'(tx_data), 32'h00);
    check("reset_tx_valid", 32'(tx_valid), 32'(0));
    check("reset_tx_last", 32'(tx_last), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_crc_timeout", 32'(crc_timeout), 32'(0));
    rst = 1'b0;
    tick();

    // Reference frame, tx_ready held high: 14 back-to-back bytes
    frame(P34, 16'h1D0F, 2, 0, 1'b0, -1, 1'b0);
    check("ref_count", 32'(acc_log.size()), 32'(PB + 2));
    check("ref_valid_cycles", 32'(valid_cnt), 32'(PB + 2));
    for (int i = 0; i < acc_log.size() && i < PB + 2; i++) begin
      check("ref_byte", 32'(acc_log[i]), 32'(exp34[i]));
      check("ref_last", 32'(last_log[i]), 32'(i == PB + 1));
    end

    // Same frame with tx_ready toggling 1/0
    frame(P34, 16'h1D0F, 3, 1, 1'b0, -1, 1'b0);
    check("toggle_count", 32'(acc_log.size()), 32'(PB + 2));
    for (int i = 0; i < acc_log.size() && i < PB + 2; i++)
      check("toggle_byte", 32'(acc_log[i]), 32'(exp34[i]));

    // crc_valid held high from before start: timeout 64 cycles after entry
    crc_valid = 1'b1;
    tick(); tick();
    valid_cnt = 0; to0 = to_cnt; first_to = -1;
    data_in_ori = P34; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (crc_timeout === 1'b1 && first_to < 0) first_to = k;
    end
    check("timeout_cycle", 32'(first_to), 32'(TO));
    check("timeout_once", 32'(to_cnt - to0), 32'(1));
    check("timeout_no_tx", 32'(valid_cnt), 32'(0));
    check("timeout_busy", 32'(busy), 32'(0));
    $display("frame %0d: held crc_valid, timeout after %0d cycles", frame_no, first_to);
    frame_no++;
    crc_valid = 1'b0;
    tick();

    // Edge on the last wait cycle wins; one cycle later is too late
    frame(P34, 16'hBEEF, TO - 1, 0, 1'b0, -1, 1'b0);
    frame(P34, 16'hBEEF, TO, 0, 1'b0, -1, 1'b0);

    // Stray start strobes (all-ones payload) during SEND
    frame(P34, 16'h1D0F, 1, 0, 1'b0, -1, 1'b1);
    check("glitch_count", 32'(acc_log.size()), 32'(PB + 2));
    for (int i = 0; i < acc_log.size() && i < PB + 2; i++)
      check("glitch_byte", 32'(acc_log[i]), 32'(exp34[i]));
    valid_cnt = 0;
    repeat (20) tick();
    check("glitch_no_second", 32'(valid_cnt), 32'(0));
    check("glitch_idle", 32'(busy), 32'(0));

    // Reset after the 5th accepted byte, then a complete fresh frame
    frame(P34, 16'h1D0F, 0, 0, 1'b0, 5, 1'b0);
    check("rst_accepted", 32'(acc_log.size()), 32'(5));
    frame(P34, 16'h1D0F, 4, 0, 1'b0, -1, 1'b0);
    check("after_rst_count", 32'(acc_log.size()), 32'(PB + 2));

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      int d;
      d = (n % 5 == 0) ? $urandom_range(TO - 3, TO + 2) : $urandom_range(0, 40);
      frame({$urandom, $urandom, $urandom}, 16'($urandom), d, $urandom_range(0, 3),
            ($urandom % 4) == 0, (($urandom % 6) == 0) ? $urandom_range(0, 15) : -1,
            ($urandom % 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
